// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the UART receiver
interface uart_rx_if;
   logic       rxd;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;

   modport master (
      output rxd,
      input  rx_byte,
      input  rx_valid,
      input  rx_frame_err,
      input  rx_busy
   );

   modport slave (
      input  rxd,
      output rx_byte,
      output rx_valid,
      output rx_frame_err,
      output rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error strobe
module uart_rx #(
   parameter int BAUD_DIV = 103
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.slave rx
);

   localparam logic [11:0] DIV  = 12'(BAUD_DIV);
   localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  byte_q, byte_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        sync1_q, sync2_q;
   logic        rxd_s;

   // Sync flops reset high so a reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx.rxd;
         sync2_q <= sync1_q;
      end
   end

   assign rxd_s = sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         WAIT_IDLE: begin
            if (rxd_s) state_d = IDLE;
         end
         IDLE: begin
            if (!rxd_s) begin
               state_d = START;
               cnt_d   = HALF;
            end
         end
         START: begin
            if (cnt_q != 12'd0) begin
               cnt_d = cnt_q - 12'd1;
            end else if (!rxd_s) begin
               state_d = DATA;
               cnt_d   = DIV;
               idx_d   = 3'd0;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (cnt_q != 12'd0) begin
               cnt_d = cnt_q - 12'd1;
            end else begin
               shift_d = {rxd_s, shift_q[7:1]};
               cnt_d   = DIV;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            // Leaving at mid-stop re-arms IDLE early enough for back-to-back frames.
            if (cnt_q != 12'd0) begin
               cnt_d = cnt_q - 12'd1;
            end else if (rxd_s) begin
               byte_d  = shift_q;
               valid_d = 1'b1;
               state_d = IDLE;
            end else begin
               err_d   = 1'b1;
               state_d = WAIT_IDLE;
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   assign rx.rx_byte      = byte_q;
   assign rx.rx_valid     = valid_q;
   assign rx.rx_frame_err = err_q;
   assign rx.rx_busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule
